// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: ALU op codes, forwarding selects and the
// multiplier FSM state encoding.
package pipeline_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_OR  = 4'h3,
    ALU_XOR = 4'h4,
    ALU_SLT = 4'h5,
    ALU_SLL = 4'h6,
    ALU_SRL = 4'h7,
    ALU_SRA = 4'h8,
    ALU_MUL = 4'h9
  } alu_op_e;

  // Select 2'b11 is not listed; the muxes fall back to the register file for it.
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs, forwarding controls and EX/MEM register outputs of the
// execute stage, bundled with a view per side.
interface ex_stage_if #(parameter int XLEN = 32);

  logic            id_ex_valid;
  logic [XLEN-1:0] id_ex_rs_data;
  logic [XLEN-1:0] id_ex_rt_data;
  logic [XLEN-1:0] id_ex_imm;
  logic [3:0]      id_ex_alu_op;
  logic            id_ex_ALUSrc;
  logic            id_ex_RegWrite;
  logic            id_ex_MemRead;
  logic            id_ex_MemWrite;
  logic            id_ex_MemToReg;
  logic [4:0]      id_ex_rd;
  logic [1:0]      fwdA;
  logic [1:0]      fwdB;
  logic [XLEN-1:0] mem_wb_wdata;

  logic            ex_stall;
  logic            ex_mem_valid;
  logic [XLEN-1:0] ex_mem_alu_result;
  logic [XLEN-1:0] ex_mem_store_data;
  logic [4:0]      ex_mem_rd;
  logic            ex_mem_RegWrite;
  logic            ex_mem_MemRead;
  logic            ex_mem_MemWrite;
  logic            ex_mem_MemToReg;

  modport slave (
    input  id_ex_valid, id_ex_rs_data, id_ex_rt_data, id_ex_imm, id_ex_alu_op,
           id_ex_ALUSrc, id_ex_RegWrite, id_ex_MemRead, id_ex_MemWrite,
           id_ex_MemToReg, id_ex_rd, fwdA, fwdB, mem_wb_wdata,
    output ex_stall, ex_mem_valid, ex_mem_alu_result, ex_mem_store_data,
           ex_mem_rd, ex_mem_RegWrite, ex_mem_MemRead, ex_mem_MemWrite,
           ex_mem_MemToReg
  );

  modport master (
    output id_ex_valid, id_ex_rs_data, id_ex_rt_data, id_ex_imm, id_ex_alu_op,
           id_ex_ALUSrc, id_ex_RegWrite, id_ex_MemRead, id_ex_MemWrite,
           id_ex_MemToReg, id_ex_rd, fwdA, fwdB, mem_wb_wdata,
    input  ex_stall, ex_mem_valid, ex_mem_alu_result, ex_mem_store_data,
           ex_mem_rd, ex_mem_RegWrite, ex_mem_MemRead, ex_mem_MemWrite,
           ex_mem_MemToReg
  );

endinterface

// File: rtl/iter_multiplier.sv
// Iterative shift-add multiplier: operands latched on start, one multiplier
// bit consumed per BUSY cycle, product held for the single DONE cycle.
module iter_multiplier
  import pipeline_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);

  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  mcand_q;
  logic [XLEN-1:0]  mplier_q;
  logic [XLEN-1:0]  acc_q;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state_q <= MUL_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MUL_IDLE: if (start) state_d = MUL_BUSY;
      MUL_BUSY: if (cnt_q == CNT_W'(XLEN - 1)) state_d = MUL_DONE;
      MUL_DONE: state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are reset as well, so a multiply abandoned
    // by reset cannot leave a stale partial product behind.
    if (!rst_n) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (state_q == MUL_IDLE && start) begin
      cnt_q    <= '0;
      mcand_q  <= multiplicand;
      mplier_q <= multiplier;
      acc_q    <= '0;
    end else if (state_q == MUL_BUSY) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end

  assign busy    = (state_q == MUL_BUSY);
  assign done    = (state_q == MUL_DONE);
  assign product = acc_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, stalling iterative MUL
// and the EX/MEM pipeline register.
module ex_stage
  import pipeline_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic     clk,
  input  logic     rst_n,
  ex_stage_if.slave bus
);

  logic [XLEN-1:0] op_a, op_b, rt_fwd, alu_result, mul_product;
  logic [4:0]      shamt;
  logic            is_mul, mul_start, mul_busy, mul_done;
  alu_op_e         alu_op;

  logic            nxt_valid;
  logic [XLEN-1:0] nxt_result, nxt_store;
  logic [4:0]      nxt_rd;
  logic [3:0]      nxt_ctrl;

  function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0]      sel,
                                              input logic [XLEN-1:0] reg_val,
                                              input logic [XLEN-1:0] exmem_val,
                                              input logic [XLEN-1:0] memwb_val);
    case (sel)
      FWD_EXMEM: return exmem_val;
      FWD_MEMWB: return memwb_val;
      default:   return reg_val;
    endcase
  endfunction

  assign alu_op = alu_op_e'(bus.id_ex_alu_op);
  assign op_a   = fwd_mux(bus.fwdA, bus.id_ex_rs_data, bus.ex_mem_alu_result, bus.mem_wb_wdata);
  assign rt_fwd = fwd_mux(bus.fwdB, bus.id_ex_rt_data, bus.ex_mem_alu_result, bus.mem_wb_wdata);
  assign op_b   = bus.id_ex_ALUSrc ? bus.id_ex_imm : rt_fwd;
  assign shamt  = op_b[4:0];

  always_comb begin
    // NOTE: default first so every path assigns the result and no latch is inferred.
    alu_result = '0;
    case (alu_op)
      ALU_ADD: alu_result = op_a + op_b;
      ALU_SUB: alu_result = op_a - op_b;
      ALU_AND: alu_result = op_a & op_b;
      ALU_OR:  alu_result = op_a | op_b;
      ALU_XOR: alu_result = op_a ^ op_b;
      ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLL: alu_result = op_a << shamt;
      ALU_SRL: alu_result = op_a >> shamt;
      ALU_SRA: alu_result = $signed(op_a) >>> shamt;
      default: alu_result = '0;
    endcase
  end

  // A MUL may only start from IDLE; once running, the held ID/EX copy is ignored.
  assign is_mul    = bus.id_ex_valid && (alu_op == ALU_MUL);
  assign mul_start = is_mul && !mul_busy && !mul_done;
  assign bus.ex_stall = rst_n && (mul_start || mul_busy);

  iter_multiplier #(.XLEN(XLEN), .CNT_W(CNT_W)) u_mul (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (mul_start),
    .multiplicand (op_a),
    .multiplier   (op_b),
    .busy         (mul_busy),
    .done         (mul_done),
    .product      (mul_product)
  );

  // Anything other than a finished MUL or a plain ALU op becomes a bubble,
  // so stall cycles never duplicate a register write.
  always_comb begin
    nxt_valid  = 1'b0;
    nxt_result = '0;
    nxt_store  = '0;
    nxt_rd     = '0;
    nxt_ctrl   = '0;
    if (bus.id_ex_valid && (mul_done || !is_mul)) begin
      nxt_valid  = 1'b1;
      nxt_result = mul_done ? mul_product : alu_result;
      nxt_store  = rt_fwd;
      nxt_rd     = bus.id_ex_rd;
      nxt_ctrl   = {bus.id_ex_RegWrite, bus.id_ex_MemRead,
                    bus.id_ex_MemWrite, bus.id_ex_MemToReg};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.ex_mem_valid      <= 1'b0;
      bus.ex_mem_alu_result <= '0;
      bus.ex_mem_store_data <= '0;
      bus.ex_mem_rd         <= '0;
      bus.ex_mem_RegWrite   <= 1'b0;
      bus.ex_mem_MemRead    <= 1'b0;
      bus.ex_mem_MemWrite   <= 1'b0;
      bus.ex_mem_MemToReg   <= 1'b0;
    end else begin
      bus.ex_mem_valid      <= nxt_valid;
      bus.ex_mem_alu_result <= nxt_result;
      bus.ex_mem_store_data <= nxt_store;
      bus.ex_mem_rd         <= nxt_rd;
      bus.ex_mem_RegWrite   <= nxt_ctrl[3];
      bus.ex_mem_MemRead    <= nxt_ctrl[2];
      bus.ex_mem_MemWrite   <= nxt_ctrl[1];
      bus.ex_mem_MemToReg   <= nxt_ctrl[0];
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed vector table, hand-written MUL/reset sequences
// and random instructions checked against an arithmetic reference model.
module tb_ex_stage;
  import pipeline_pkg::*;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  ex_stage_if #(.XLEN(XLEN)) bus ();

  ex_stage #(.XLEN(XLEN), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ctrl = {RegWrite, MemRead, MemWrite, MemToReg}
  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [31:0] rs, rt, imm;
    logic        alusrc;
    logic [1:0]  fa, fb;
    logic [31:0] wb;
    logic [4:0]  rd;
    logic [3:0]  ctrl;
  } instr_t;

  typedef struct packed {
    instr_t      ins;
    logic [31:0] exp_res;
    logic [31:0] exp_store;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  function automatic instr_t mk(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                input logic [31:0] imm, input logic alusrc, input logic [1:0] fa,
                                input logic [1:0] fb, input logic [31:0] wb, input logic [4:0] rd,
                                input logic [3:0] ctrl);
    instr_t i;
    i.valid = 1'b1; i.op = op; i.rs = rs; i.rt = rt; i.imm = imm; i.alusrc = alusrc;
    i.fa = fa; i.fb = fb; i.wb = wb; i.rd = rd; i.ctrl = ctrl;
    return i;
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] regv,
                                          input logic [31:0] exmem, input logic [31:0] memwb);
    if (sel == 2'b10) return exmem;
    if (sel == 2'b01) return memwb;
    return regv;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return a << sh;
      4'd7: return a >> sh;
      4'd8: return 32'($signed(a) >>> sh);
      4'd9: return a * b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input instr_t i);
    bus.id_ex_valid    = i.valid;
    bus.id_ex_alu_op   = i.op;
    bus.id_ex_rs_data  = i.rs;
    bus.id_ex_rt_data  = i.rt;
    bus.id_ex_imm      = i.imm;
    bus.id_ex_ALUSrc   = i.alusrc;
    bus.fwdA           = i.fa;
    bus.fwdB           = i.fb;
    bus.mem_wb_wdata   = i.wb;
    bus.id_ex_rd       = i.rd;
    bus.id_ex_RegWrite = i.ctrl[3];
    bus.id_ex_MemRead  = i.ctrl[2];
    bus.id_ex_MemWrite = i.ctrl[1];
    bus.id_ex_MemToReg = i.ctrl[0];
  endtask

  task automatic check_out(input string name, input instr_t i, input logic [31:0] exp_res,
                           input logic [31:0] exp_store, input bit chk_store);
    check({name, "_result"}, bus.ex_mem_alu_result, exp_res);
    if (chk_store) check({name, "_store"}, bus.ex_mem_store_data, exp_store);
    check({name, "_ctrl"},
          {bus.ex_mem_valid, bus.ex_mem_rd, bus.ex_mem_RegWrite, bus.ex_mem_MemRead,
           bus.ex_mem_MemWrite, bus.ex_mem_MemToReg},
          i.valid ? {1'b1, i.rd, i.ctrl} : 10'b0);
  endtask

  // Holds the instruction in ID/EX until the stage stops stalling; returns at
  // the negedge where EX/MEM shows the instruction's result.
  task automatic issue(input instr_t i, input int mid_at, input logic [31:0] mid_wb,
                       output int stalls, output int bad);
    bit done;
    done   = 1'b0;
    stalls = 0;
    bad    = 0;
    drive(i);
    for (int g = 0; g < 100 && !done; g++) begin
      #1;
      if (bus.ex_stall) begin
        stalls++;
        if (stalls > 1 && bus.ex_mem_valid) bad++;
        if (stalls == mid_at) bus.mem_wb_wdata = mid_wb;
      end else begin
        if (stalls > 0 && bus.ex_mem_valid) bad++;
        done = 1'b1;
      end
      @(negedge clk);
    end
    check("issue_completes", 64'(done), 64'd1);
  endtask

  initial begin
    instr_t      ins;
    int          st, bad, c1, c2, seen, mul_budget;
    logic [31:0] exp_res, a, rtf, b, res, store;

    vecs[0]  = '{mk(4'd0, 32'd5, 32'd7, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd3, 4'b1000), 32'd12, 32'd7};
    vecs[1]  = '{mk(4'd0, 32'd60, 32'd40, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd4, 4'b1000), 32'd100, 32'd40};
    vecs[2]  = '{mk(4'd0, 32'd999, 32'd7, 32'd0, 1'b0, 2'b10, 2'b00, 32'd0, 5'd5, 4'b1000), 32'd107, 32'd7};
    vecs[3]  = '{mk(4'd0, 32'd999, 32'd7, 32'd0, 1'b0, 2'b01, 2'b00, 32'h10, 5'd6, 4'b1000), 32'h17, 32'd7};
    vecs[4]  = '{mk(4'd1, 32'd3, 32'd5, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd7, 4'b1000), 32'hFFFF_FFFE, 32'd5};
    vecs[5]  = '{mk(4'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd8, 4'b1000), 32'd1, 32'd1};
    vecs[6]  = '{mk(4'd8, 32'h8000_0000, 32'h55, 32'd4, 1'b1, 2'b00, 2'b00, 32'd0, 5'd9, 4'b1000), 32'hF800_0000, 32'h55};
    vecs[7]  = '{mk(4'd0, 32'h100, 32'h1234, 32'd8, 1'b1, 2'b00, 2'b01, 32'hDEAD, 5'd0, 4'b0010), 32'h108, 32'hDEAD};
    vecs[8]  = '{mk(4'd0, 32'd1, 32'd2, 32'd0, 1'b0, 2'b11, 2'b11, 32'd50, 5'd10, 4'b1000), 32'd3, 32'd2};
    vecs[9]  = '{mk(4'd6, 32'd1, 32'd31, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd11, 4'b1000), 32'h8000_0000, 32'd31};
    vecs[10] = '{mk(4'd7, 32'h8000_0000, 32'h21, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd12, 4'b1000), 32'h4000_0000, 32'h21};
    vecs[11] = '{mk(4'd2, 32'hF0F0, 32'h0FF0, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd13, 4'b1000), 32'h00F0, 32'h0FF0};
    vecs[12] = '{mk(4'd3, 32'hF0F0, 32'h0FF0, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd14, 4'b1000), 32'hFFF0, 32'h0FF0};
    vecs[13] = '{mk(4'd4, 32'hF0F0, 32'h0FF0, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd15, 4'b1000), 32'hFF00, 32'h0FF0};
    vecs[14] = '{mk(4'hF, 32'd123, 32'd456, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd16, 4'b1000), 32'd0, 32'd456};
    vecs[15] = '{mk(4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd17, 4'b1000), 32'd0, 32'd0};
    vecs[15].ins.valid = 1'b0;
    vecs[16] = '{mk(4'd0, 32'h200, 32'd9, 32'd4, 1'b1, 2'b00, 2'b00, 32'd0, 5'd18, 4'b1101), 32'h204, 32'd9};

    // Reset held two cycles with a valid ADD presented.
    rst_n = 1'b0;
    drive(vecs[0].ins);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("reset%0d_outputs", k),
            {bus.ex_mem_valid, bus.ex_mem_alu_result, bus.ex_mem_store_data, bus.ex_mem_rd,
             bus.ex_mem_RegWrite, bus.ex_mem_MemRead, bus.ex_mem_MemWrite, bus.ex_mem_MemToReg},
            64'd0);
      check($sformatf("reset%0d_stall", k), 64'(bus.ex_stall), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < NV; k++) begin
      issue(vecs[k].ins, -1, 32'd0, st, bad);
      check($sformatf("vec%0d_stall", k), 64'(st), 64'd0);
      check_out($sformatf("vec%0d", k), vecs[k].ins, vecs[k].exp_res, vecs[k].exp_store, 1'b1);
    end

    // MUL 6 x 7: 33 stall cycles, bubbles throughout, then the product.
    ins = mk(4'd9, 32'd6, 32'd7, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd20, 4'b1000);
    issue(ins, -1, 32'd0, st, bad);
    check("mul6x7_stall_cycles", 64'(st), 64'd33);
    check("mul6x7_bubbles", 64'(bad), 64'd0);
    check_out("mul6x7", ins, 32'd42, 32'd7, 1'b1);

    // Operand A forwarded from MEM/WB; write-back data changes mid-multiply.
    ins = mk(4'd9, 32'd999, 32'd7, 32'd0, 1'b0, 2'b01, 2'b00, 32'd6, 5'd21, 4'b1000);
    issue(ins, 10, 32'd1000, st, bad);
    check("mul_fwd_stall_cycles", 64'(st), 64'd33);
    check_out("mul_fwd_latched", ins, 32'd42, 32'd7, 1'b0);

    // Back-to-back MULs, the second one all-ones squared.
    ins = mk(4'd9, 32'd3, 32'd4, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd22, 4'b1000);
    issue(ins, -1, 32'd0, st, bad);
    c1 = cyc;
    check_out("mul_b2b_first", ins, 32'd12, 32'd4, 1'b1);
    ins = mk(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd23, 4'b1000);
    issue(ins, -1, 32'd0, st, bad);
    c2 = cyc;
    check_out("mul_ones", ins, 32'd1, 32'hFFFF_FFFF, 1'b1);
    check("mul_b2b_spacing", 64'(c2 - c1), 64'd34);
    check("mul_b2b_bubbles", 64'(bad), 64'd0);

    // Reset while BUSY: the multiply is abandoned and never written.
    ins = mk(4'd9, 32'd9, 32'd9, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd24, 4'b1000);
    drive(ins);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    bus.id_ex_valid = 1'b0;
    @(negedge clk);
    #1;
    check("rst_busy_stall", 64'(bus.ex_stall), 64'd0);
    check("rst_busy_valid", 64'(bus.ex_mem_valid), 64'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (bus.ex_mem_valid || bus.ex_stall) seen++;
    end
    check("rst_busy_no_result", 64'(seen), 64'd0);
    ins = mk(4'd0, 32'd2, 32'd3, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd25, 4'b1000);
    issue(ins, -1, 32'd0, st, bad);
    check_out("add_after_reset", ins, 32'd5, 32'd3, 1'b1);

    // Random instructions against the reference model.
    exp_res    = 32'd5;
    mul_budget = 6;
    for (int r = 0; r < 300; r++) begin
      ins.valid = ($urandom_range(0, 7) != 0);
      ins.op    = 4'($urandom_range(0, 15));
      if (ins.op == 4'd9) begin
        if (mul_budget > 0) mul_budget--;
        else ins.op = 4'd4;
      end
      ins.rs     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
      ins.rt     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
      ins.imm    = 32'($urandom);
      ins.alusrc = 1'($urandom_range(0, 1));
      ins.fa     = 2'($urandom_range(0, 3));
      ins.fb     = 2'($urandom_range(0, 3));
      ins.wb     = 32'($urandom);
      ins.rd     = 5'($urandom_range(0, 31));
      ins.ctrl   = 4'($urandom_range(0, 15));

      a     = ref_fwd(ins.fa, ins.rs, exp_res, ins.wb);
      rtf   = ref_fwd(ins.fb, ins.rt, exp_res, ins.wb);
      b     = ins.alusrc ? ins.imm : rtf;
      res   = ins.valid ? ref_alu(ins.op, a, b) : 32'd0;
      store = ins.valid ? rtf : 32'd0;

      issue(ins, -1, 32'd0, st, bad);
      check($sformatf("rand%0d_stall", r), 64'(st),
            (ins.valid && ins.op == 4'd9) ? 64'd33 : 64'd0);
      check($sformatf("rand%0d_bubbles", r), 64'(bad), 64'd0);
      check_out($sformatf("rand%0d", r), ins, res, store, !(ins.valid && ins.op == 4'd9));
      exp_res = res;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline; consumes the ID/EX register contents and the fwdA/fwdB selects from the forwarding unit.
- Forwarding muxes pick each operand from the register file, the EX/MEM result (owned by this block) or the MEM/WB write-back data.
- Single-cycle ALU operations complete in one cycle; MUL runs on an iterative shift-add multiplier that stalls the front end.
- Registers its outputs into the EX/MEM pipeline register.

Parameters:
- XLEN, 32, datapath width; MUL runs XLEN iterations.
- CNT_W, 5, multiply iteration counter width; must equal clog2(XLEN).

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- id_ex_valid  in  1  ID/EX holds a real instruction
- id_ex_rs_data  in  XLEN  register-file value of rs
- id_ex_rt_data  in  XLEN  register-file value of rt
- id_ex_imm  in  XLEN  sign-extended immediate
- id_ex_alu_op  in  4  ALU operation code
- id_ex_ALUSrc  in  1  1 = operand B is imm
- id_ex_RegWrite, id_ex_MemRead, id_ex_MemWrite, id_ex_MemToReg  in  1 each  control bits
- id_ex_rd  in  5  destination register
- fwdA, fwdB  in  2  00 = regfile, 10 = EX/MEM result, 01 = MEM/WB data, 11 = treated as 00
- mem_wb_wdata  in  XLEN  write-back data
- ex_stall  out  1  hold PC, IF/ID and ID/EX this cycle
- ex_mem_valid  out  1  EX/MEM holds a real instruction
- ex_mem_alu_result  out  XLEN  ALU or MUL result
- ex_mem_store_data  out  XLEN  forwarded rt value for stores
- ex_mem_rd  out  5  destination register
- ex_mem_RegWrite, ex_mem_MemRead, ex_mem_MemWrite, ex_mem_MemToReg  out  1 each  registered control bits

Behaviour:
- Reset (rst_n low at posedge): all ex_mem_* outputs = 0, FSM = IDLE, counter = 0, ex_stall = 0. Reset mid-multiply abandons the operation; no result is written.
- Operand A = fwd mux(rs). Operand B = id_ex_imm if ALUSrc = 1, else fwd mux(rt). Store data = fwd mux(rt), always, independent of ALUSrc.
- ALU ops:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 SLT: signed compare, result 1 or 0
  - 0110 SLL, 0111 SRL, 1000 SRA: shift amount = B[4:0]
  - 1001 MUL: low XLEN bits of the product, sign-agnostic
  - all other codes: result 0
  - ADD/SUB wrap modulo 2^XLEN; no overflow flag.
- Non-MUL op, valid = 1: EX/MEM captures result, store data, rd and control at the next posedge (latency 1). ex_stall = 0.
- id_ex_valid = 0: EX/MEM captures a bubble (valid and all control bits 0; data fields don't-care, implemented as 0).
- MUL FSM, states IDLE, BUSY, DONE:
  - IDLE with valid MUL: ex_stall = 1 combinationally. At the posedge, latch forwarded operands A and B into the multiplier (later forwarding changes are ignored), clear the accumulator, set counter = 0, go to BUSY. EX/MEM receives a bubble.
  - BUSY: ex_stall = 1. Each cycle: if multiplier bit 0 = 1, accumulator += multiplicand; then multiplicand <<= 1 and multiplier >>= 1. Counter increments; when counter reaches XLEN-1, go to DONE. EX/MEM receives a bubble every cycle.
  - DONE: ex_stall = 0. EX/MEM captures the product with the instruction's rd and control bits (ID/EX has been held, so they are still valid). Go to IDLE.
  - Timing: stall is high for XLEN+1 cycles; the instruction occupies EX for XLEN+2 cycles.
- Back-to-back MULs: the second MUL is seen in IDLE on the cycle after DONE and starts normally. There is no overlap.
- A register write in EX/MEM must never be duplicated: during stall cycles EX/MEM holds bubbles, never a copy of the previous instruction.
- Forwarding select 11 is treated identically to 00.

Decomposition:
- Shared package pipeline_pkg holds: ALU op encodings (ALU_ADD … ALU_MUL), forwarding select constants (FWD_REG, FWD_EXMEM, FWD_MEMWB), and the FSM state encodings.
- One sub-module, iter_multiplier: start, operands, busy/done, product. The FSM lives inside it; ex_stage derives ex_stall from it.
- Forwarding muxes and the ALU stay combinational in ex_stage.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with valid ADD inputs -> all ex_mem_* = 0 and ex_stall = 0 throughout.
- ADD, rs = 5, rt = 7, fwd 00/00 -> next cycle ex_mem_alu_result = 12, RegWrite = 1, rd passed through. Same with fwdA = 10 while ex_mem_alu_result = 100 -> 107.
- SUB 3 - 5 -> 0xFFFFFFFE. SLT with -1 vs 1 -> 1. SRA of 0x80000000 by 4 -> 0xF8000000. Store with fwdB = 01, mem_wb_wdata = 0xDEAD, ALUSrc = 1 -> ex_mem_store_data = 0xDEAD.
- MUL 6 × 7 -> ex_stall high exactly 33 cycles, ex_mem_valid = 0 during the stall, then one cycle with result = 42 and RegWrite = 1. Change mem_wb_wdata mid-multiply -> result unchanged.
- MUL 0xFFFFFFFF × 0xFFFFFFFF -> 0x00000001. Back-to-back MULs -> two results exactly 34 cycles apart.
- Assert rst_n = 0 during BUSY -> next cycle ex_stall = 0 and no MUL result is ever written. A following ADD completes normally.
